// File: rtl/magnitude_cordic_hs.sv
// Iterative CORDIC vectoring magnitude unit: sqrt(X^2+Y^2) with gain compensation,
// valid/ready handshakes on both sides and one micro-rotation per clock.
module magnitude_cordic_hs #(
    parameter int W     = 12,
    parameter int ITER  = 12,
    parameter int GUARD = 3
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] X,
    input  logic signed [W-1:0] Y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W:0]          Magnitude,
    output logic                busy
);

    // Two spare integer bits cover |-2^(W-1)| and the ~1.647 CORDIC gain.
    localparam int IW = W + 2 + GUARD;
    localparam int CW = $clog2(W + 3);
    localparam int PW = IW + 17;
    localparam int SH = 16 + GUARD;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        SCALE,
        DONE
    } state_t;

    state_t state, nextState;

    logic signed [IW-1:0] xReg, yReg;
    logic signed [IW-1:0] xIn, yIn;
    logic signed [IW-1:0] xShift, yShift;
    logic [CW-1:0]        iter;
    logic                 lastIter;
    logic [PW-1:0]        prod, rounded;
    logic [W:0]           magNext;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (in_valid)  nextState = ROTATE;
            ROTATE:  if (lastIter)  nextState = SCALE;
            SCALE:                  nextState = DONE;
            DONE:    if (out_ready) nextState = IDLE;
            default:                nextState = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == ROTATE) || (state == SCALE);
    assign out_valid = (state == DONE);
    assign lastIter  = (iter == CW'(ITER - 1));

    // X is folded into the right half-plane so the vectoring always converges.
    assign xIn    = (X[W-1] ? -IW'(X) : IW'(X)) <<< GUARD;
    assign yIn    = IW'(Y) <<< GUARD;
    assign xShift = xReg >>> iter;
    assign yShift = yReg >>> iter;

    // x only grows during vectoring, so it is non-negative and can be scaled unsigned.
    assign prod    = {{(PW - IW){1'b0}}, xReg} * PW'(39797);
    assign rounded = (prod + (PW'(1) << (SH - 1))) >> SH;
    assign magNext = (|rounded[PW-1:W+1]) ? '1 : rounded[W:0];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            xReg      <= '0;
            yReg      <= '0;
            iter      <= '0;
            Magnitude <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xReg <= xIn;
                        yReg <= yIn;
                        iter <= '0;
                    end
                end
                ROTATE: begin
                    if (!yReg[IW-1]) begin
                        xReg <= xReg + yShift;
                        yReg <= yReg - xShift;
                    end else begin
                        xReg <= xReg - yShift;
                        yReg <= yReg + xShift;
                    end
                    iter <= iter + CW'(1);
                end
                SCALE: begin
                    Magnitude <= magNext;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/magnitude_cordic_hs.md
Name: magnitude_cordic_hs

Overview:
Parametrised successor to the fixed 12-bit magnitude unit. Computes sqrt(X^2+Y^2) of one signed (X,Y) sample with an iterative CORDIC vectoring engine followed by gain compensation. Input and output use valid/ready handshakes so the block can sit between the sample source and the downstream consumer with back-pressure.

Parameters:
W, 12, signed input width of X and Y; Magnitude is W+1 bits.
ITER, 12, CORDIC micro-rotations (1..W+2); one per clock.
GUARD, 3, extra fractional LSBs carried in the datapath.

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  asynchronous, active-high reset
in_valid  input  1  X/Y valid
in_ready  output  1  block can accept a sample
X  input  W  signed two's-complement X
Y  input  W  signed two's-complement Y
out_valid  output  1  Magnitude valid
out_ready  input  1  consumer accepts Magnitude
Magnitude  output  W+1  unsigned result, rounded, saturated
busy  output  1  high in ROTATE or SCALE

Behaviour:
- Reset (async, any time incl. mid-operation): state=IDLE, out_valid=0, Magnitude=0, busy=0, iteration counter=0, datapath regs=0; in_ready=1 once Reset deasserts.
- in_ready = (state==IDLE), combinational from state. Accept = in_valid & in_ready at rising edge.
- FSM: IDLE -accept-> ROTATE; ROTATE -(i==ITER-1)-> SCALE; SCALE -> DONE; DONE -(out_ready)-> IDLE. No other transitions.
- Accept: x <= |X| << GUARD, y <= Y << GUARD (sign-extended), i <= 0. Internal width W+2+GUARD (covers |-2^(W-1)| and CORDIC growth ~1.647).
- ROTATE, per cycle: y>=0: x += y>>>i, y -= x>>>i; else x -= y>>>i, y += x>>>i (both updates use pre-update values, arithmetic shifts); i++.
- SCALE: p = x * 16'd39797 (1/K in Q16, K=1.64676); Magnitude <= round(p >> (16+GUARD)) (add half-LSB, then truncate); if result > 2^(W+1)-1, saturate to 2^(W+1)-1; out_valid <= 1.
- DONE: Magnitude and out_valid held stable while out_ready=0. On edge with out_ready=1: out_valid <= 0, state IDLE; Magnitude keeps last value.
- Latency: accept at edge t -> out_valid=1 after edge t+ITER+1. Minimum issue interval ITER+3 cycles (with out_ready tied high).
- in_valid while busy or in DONE: ignored, no effect on in-flight computation; source must hold X/Y until in_ready.
- out_ready while out_valid=0: ignored.
- Accuracy: |Magnitude - round(true)| <= 2 LSB for ITER>=W; X=Y=0 gives exactly 0.
- Pure sequential datapath; X/Y sampled only on accept, so input changes after accept have no effect.

Test Plan:
- Reset: Reset=1 mid-ROTATE (after accept of X=952,Y=376) -> immediately out_valid=0, Magnitude=0, busy=0; after release in_ready=1, next sample computed correctly.
- Basic, W=12, ITER=12, out_ready=1: X=952,Y=376 -> Magnitude 1024±2, out_valid exactly 13 cycles after accept edge, pulse 1 cycle; X=-65,Y=1021 -> 1023±2; X=3,Y=-4 -> 5±1.
- Extremes: X=-2048,Y=-2048 -> 2896±2 (no overflow); X=0,Y=0 -> 0; X=2047,Y=0 -> 2047±1; X=0,Y=-2048 -> 2048±1.
- Back-pressure: out_ready=0 for 10 cycles after out_valid -> Magnitude/out_valid stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next edge, following sample accepted.
- Sweep: the ten-point circle set (X,Y)=(952,376),(548,864),(-65,1021),(-653,789),(-992,254),(-953,-377),(-549,-865),(64,-1022),(652,-790),(991,-255) streamed back-to-back -> all 1021..1026, one result per ITER+3 cycles, order preserved.
- Parametrisation: W=16, ITER=16: X=-32768,Y=0 -> 32768±2; X=30000,Y=-40000 invalid (out of range, skip) -> use X=18000,Y=-24000 -> 30000±2.
